// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
// Included by every file of the register-file slice.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_32x64_if.sv
// Read/write port bundle of the register file.
// master = datapath side, slave = register file.
interface regfile_if;
  import regfile_pkg::*;

  reg_addr_t rdAddrA;
  reg_addr_t rdAddrB;
  reg_data_t rdDataA;
  reg_data_t rdDataB;
  reg_addr_t wrAddr;
  reg_data_t wrData;
  logic      write;

  modport master (
    output rdAddrA, rdAddrB,
    output wrAddr, wrData, write,
    input  rdDataA, rdDataB
  );

  modport slave (
    input  rdAddrA, rdAddrB,
    input  wrAddr, wrData, write,
    output rdDataA, rdDataB
  );

endinterface

// File: rtl/regfile_32x64_row64.sv
// One 64-bit register row with async active-low clear
// and a load enable driven by the write decoder.
module regfile_row64
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  reg_data_t d,
  output reg_data_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: 2 async read ports, 1 sync write port.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  regfile_if.slave rf
);

  logic [NUM_REGS-1:0] loadVec;
  reg_data_t           rows [NUM_REGS];
  reg_data_t           muxA;
  reg_data_t           muxB;

  // one-hot write decoder; at most one row loads per edge
  always_comb begin
    loadVec = '0;
    if (rf.write) begin
      loadVec[rf.wrAddr] = 1'b1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : gRow
      regfile_row64 uRow (
        .clk   (clk),
        .reset (reset),
        .load  (loadVec[i]),
        .d     (rf.wrData),
        .q     (rows[i])
      );
    end
  endgenerate

  assign muxA = rows[rf.rdAddrA];
  assign muxB = rows[rf.rdAddrB];

`ifdef REGFILE_BYPASS_EN
  logic hitA;
  logic hitB;

  assign hitA = rf.write & reset & (rf.wrAddr == rf.rdAddrA);
  assign hitB = rf.write & reset & (rf.wrAddr == rf.rdAddrB);

  assign rf.rdDataA = hitA ? rf.wrData : muxA;
  assign rf.rdDataB = hitB ? rf.wrData : muxB;
`else
  assign rf.rdDataA = muxA;
  assign rf.rdDataB = muxB;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64 with a queue-based scoreboard.
module tb_regfile_32x64;
  import regfile_pkg::*;

  logic clk;
  logic reset;

  regfile_if rf ();

  regfile_32x64 dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string     name;
    reg_data_t expA;
    reg_data_t expB;
  } exp_t;

  exp_t q[$];
  event sample;
  int   nChecks = 0;
  int   nFails  = 0;

  localparam reg_data_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam reg_data_t PATA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam reg_data_t PATC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam reg_data_t PATF = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam reg_data_t PAT7 = 64'h0123_4567_89AB_CDEF;

  // monitor: pops one expectation per presented sample
  initial begin
    exp_t e;
    forever begin
      @(sample);
      while (q.size() > 0) begin
        e = q.pop_front();
        nChecks++;
        if (rf.rdDataA !== e.expA) begin
          nFails++;
          $display("FAIL %s portA: got %h want %h",
                   e.name, rf.rdDataA, e.expA);
        end
        nChecks++;
        if (rf.rdDataB !== e.expB) begin
          nFails++;
          $display("FAIL %s portB: got %h want %h",
                   e.name, rf.rdDataB, e.expB);
        end
      end
    end
  end

  task automatic expectRd(input string n,
                          input reg_addr_t a, input reg_addr_t b,
                          input reg_data_t ea, input reg_data_t eb);
    rf.rdAddrA = a;
    rf.rdAddrB = b;
    #1;
    q.push_back('{n, ea, eb});
    ->sample;
    #1;
  endtask

  task automatic edgeThen();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  reg_data_t pre6;

  initial begin
    reset      = 1'b0;
    rf.rdAddrA = '0;
    rf.rdAddrB = '0;
    rf.wrAddr  = '0;
    rf.wrData  = ONES;
    rf.write   = 1'b1;

    // writes attempted under reset are ignored
    repeat (3) edgeThen();
    expectRd("rst_0_31", 5'd0, 5'd31, '0, '0);
    rf.write = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    rf.wrAddr = 5'd0;
    rf.wrData = ONES;
    rf.write  = 1'b1;
    edgeThen();
    rf.write = 1'b0;
    expectRd("wr0_ones", 5'd0, 5'd0, ONES, ONES);

    rf.wrAddr = 5'd1;
    rf.wrData = PATA;
    rf.write  = 1'b1;
    edgeThen();
    rf.write = 1'b0;
    expectRd("wr1_A", 5'd0, 5'd1, ONES, PATA);
    expectRd("only_one", 5'd2, 5'd31, '0, '0);

    rf.wrData = PATC;
    repeat (3) edgeThen();
    expectRd("nowrite", 5'd0, 5'd1, ONES, PATA);

    // write held across several edges
    rf.wrAddr = 5'd7;
    rf.wrData = PAT7;
    rf.write  = 1'b1;
    repeat (3) edgeThen();
    rf.write = 1'b0;
    expectRd("hold7", 5'd7, 5'd1, PAT7, PATA);

    // read-during-write to the same address
    @(negedge clk);
    rf.wrAddr = 5'd3;
    rf.wrData = PATF;
    rf.write  = 1'b1;
`ifdef REGFILE_BYPASS_EN
    pre6 = PATF;
`else
    pre6 = '0;
`endif
    expectRd("rdw_pre", 5'd3, 5'd3, pre6, pre6);
    expectRd("rdw_other", 5'd3, 5'd7, pre6, PAT7);
    edgeThen();
    rf.write = 1'b0;
    expectRd("rdw_post", 5'd3, 5'd3, PATF, PATF);

    // async reset between edges with a write pending
    @(negedge clk);
    rf.wrAddr = 5'd1;
    rf.wrData = PATC;
    rf.write  = 1'b1;
    #2;
    reset = 1'b0;
    expectRd("rst_mid", 5'd0, 5'd1, '0, '0);
    edgeThen();
    expectRd("rst_held", 5'd3, 5'd7, '0, '0);
    rf.write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    edgeThen();
    expectRd("after_rst", 5'd1, 5'd0, '0, '0);

    #5;
    if (q.size() != 0) begin
      nFails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
